// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - two-byte instruction fetch sequencer feeding a 16-bit instruction register
// Owns the program counter; low byte is written first, then high byte, then Done pulses.
module fetch_controller #(
  parameter int A = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         PCLoad,
  input  logic [A-1:0] PCIn,
  input  logic         MemAck,
  input  logic [7:0]   MemData,
  output logic         MemRead,
  output logic [A-1:0] MemAddr,
  output logic [A-1:0] PCOut,
  output logic [7:0]   IRData,
  output logic         IRWrite,
  output logic         IRLH,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    WRITE_HI = 2'd3
  } state_t;

  localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

  state_t       state;
  logic [A-1:0] pc;

  assign PCOut   = pc;
  assign MemAddr = pc;
  assign Busy    = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      MemRead <= 1'b0;
      IRData  <= 8'h00;
      IRWrite <= 1'b0;
      IRLH    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done    <= 1'b0;
          IRWrite <= 1'b0;
          // A PC load takes priority over a fetch request in the same cycle.
          if (PCLoad) begin
            pc <= PCIn;
          end else if (Start) begin
            MemRead <= 1'b1;
            state   <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          IRWrite <= 1'b0;
          if (MemAck) begin
            IRData  <= MemData;
            IRWrite <= 1'b1;
            IRLH    <= 1'b0;
            pc      <= pc + PC_ONE;
            state   <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          IRWrite <= 1'b0;
          if (MemAck) begin
            IRData  <= MemData;
            IRWrite <= 1'b1;
            IRLH    <= 1'b1;
            pc      <= pc + PC_ONE;
            MemRead <= 1'b0;
            state   <= WRITE_HI;
          end
        end
        WRITE_HI: begin
          // High-byte write is visible this cycle; Done marks the first IDLE cycle.
          IRWrite <= 1'b0;
          Done    <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized self-checking bench for fetch_controller
module tb_fetch_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       PCLoad;
  logic [7:0] PCIn;
  logic       MemAck;
  logic [7:0] MemData;
  logic       MemRead;
  logic [7:0] MemAddr;
  logic [7:0] PCOut;
  logic [7:0] IRData;
  logic       IRWrite;
  logic       IRLH;
  logic       Busy;
  logic       Done;

  logic [7:0]  mem [256];
  logic [15:0] ir;
  logic [7:0]  model_pc;
  int          errors = 0;
  int          checks = 0;

  fetch_controller #(.A(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad), .PCIn(PCIn),
    .MemAck(MemAck), .MemData(MemData), .MemRead(MemRead), .MemAddr(MemAddr),
    .PCOut(PCOut), .IRData(IRData), .IRWrite(IRWrite), .IRLH(IRLH),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Instruction register attached downstream of the sequencer.
  always @(posedge Clock) begin
    if (IRWrite) begin
      if (IRLH) ir[15:8] <= IRData;
      else      ir[7:0]  <= IRData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_noise();
    Start  = 1'($urandom % 2);
    PCLoad = 1'($urandom % 2);
    PCIn   = 8'($urandom);
  endtask

  task automatic idle_cycle();
    Start = 1'b0; PCLoad = 1'b0; MemAck = 1'b1; MemData = 8'($urandom);
    @(negedge Clock);
    check("idle_wr", IRWrite, 0);
    check("idle_done", Done, 0);
    check("idle_busy", Busy, 0);
    check("idle_rd", MemRead, 0);
    check("idle_pc", PCOut, model_pc);
  endtask

  task automatic load_pc(input logic [7:0] v, input logic with_start);
    Start = with_start; PCLoad = 1'b1; PCIn = v; MemAck = 1'b0;
    @(negedge Clock);
    model_pc = v;
    check("load_pc", PCOut, model_pc);
    check("load_busy", Busy, 0);
    check("load_rd", MemRead, 0);
  endtask

  // Called at a negedge while idle; returns at the negedge of the Done cycle.
  task automatic do_fetch(input int dlo, input int dhi);
    logic [7:0] p, p1, p2;
    p = model_pc; p1 = p + 8'd1; p2 = p + 8'd2;
    Start = 1'b1; PCLoad = 1'b0; MemAck = 1'($urandom % 2); MemData = 8'($urandom);
    @(negedge Clock);
    for (int k = 0; k <= dlo; k++) begin
      check("lo_rd", MemRead, 1);
      check("lo_addr", MemAddr, p);
      check("lo_busy", Busy, 1);
      check("lo_wr", IRWrite, 0);
      check("lo_done", Done, 0);
      drive_noise();
      MemAck  = (k == dlo);
      MemData = (k == dlo) ? mem[p] : 8'($urandom);
      @(negedge Clock);
    end
    for (int k = 0; k <= dhi; k++) begin
      check("hi_wr", IRWrite, (k == 0));
      check("hi_lh", IRLH, 0);
      check("hi_data", IRData, mem[p]);
      check("hi_rd", MemRead, 1);
      check("hi_addr", MemAddr, p1);
      check("hi_done", Done, 0);
      drive_noise();
      MemAck  = (k == dhi);
      MemData = (k == dhi) ? mem[p1] : 8'($urandom);
      @(negedge Clock);
    end
    check("wh_wr", IRWrite, 1);
    check("wh_lh", IRLH, 1);
    check("wh_data", IRData, mem[p1]);
    check("wh_rd", MemRead, 0);
    check("wh_busy", Busy, 1);
    check("wh_done", Done, 0);
    check("wh_pc", PCOut, p2);
    drive_noise();
    MemAck = 1'($urandom % 2);
    @(negedge Clock);
    check("dn_done", Done, 1);
    check("dn_busy", Busy, 0);
    check("dn_wr", IRWrite, 0);
    check("dn_lh", IRLH, 1);
    check("dn_rd", MemRead, 0);
    check("dn_pc", PCOut, p2);
    check("dn_ir", ir, {mem[p1], mem[p]});
    model_pc = p2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;
    ir = 16'h0000;
    Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = 8'h00; MemAck = 1'b0; MemData = 8'h00;
    model_pc = 8'h00;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_pc", PCOut, 0);
    check("rst_rd", MemRead, 0);
    check("rst_wr", IRWrite, 0);
    check("rst_done", Done, 0);
    check("rst_busy", Busy, 0);

    load_pc(8'h10, 1'b0);
    do_fetch(0, 0);
    check("dir_ir", ir, 16'h1234);
    check("dir_pc", PCOut, 8'h12);
    idle_cycle();

    load_pc(8'h10, 1'b0);
    do_fetch(3, 3);
    idle_cycle();

    load_pc(8'hFF, 1'b0);
    do_fetch(0, 0);
    check("wrap_pc", PCOut, 8'h01);
    idle_cycle();

    load_pc(8'h5A, 1'b1);
    idle_cycle();
    idle_cycle();

    // Reset while waiting for the high byte.
    Start = 1'b1; PCLoad = 1'b0; MemAck = 1'b0;
    @(negedge Clock);
    Start = 1'b0; MemAck = 1'b1; MemData = mem[model_pc];
    @(negedge Clock);
    check("mr_lo_wr", IRWrite, 1);
    MemAck = 1'b0;
    @(negedge Clock);
    check("mr_hi_busy", Busy, 1);
    #2 Reset = 1'b1;
    #1;
    check("mr_pc", PCOut, 0);
    check("mr_rd", MemRead, 0);
    check("mr_wr", IRWrite, 0);
    check("mr_lh", IRLH, 0);
    check("mr_data", IRData, 0);
    check("mr_done", Done, 0);
    check("mr_busy", Busy, 0);
    MemAck = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_pc = 8'h00;
    for (int i = 0; i < 3; i++) idle_cycle();
    do_fetch(1, 0);
    idle_cycle();

    for (int it = 0; it < 40; it++) begin
      case ($urandom % 4)
        0: load_pc(8'($urandom), 1'($urandom % 2));
        1: idle_cycle();
        default: ;
      endcase
      do_fetch(int'($urandom % 4), int'($urandom % 4));
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
